// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, accumulator FSM state
// encoding and output saturation bounds for the default activation width.
package cnn_pkg;

  localparam int DEFAULT_IN_W   = 16;
  localparam int DEFAULT_CNT_W  = 4;
  localparam int DEFAULT_ACC_W  = 24;
  localparam int DEFAULT_BIAS_W = 16;
  localparam int DEFAULT_OUT_W  = 8;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_POST = 1'b1
  } acc_state_t;

  localparam int SAT_MAX = (2 ** (DEFAULT_OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEFAULT_OUT_W - 1));

endpackage

// File: rtl/mac_accumulator_if.sv
// Product input stream and result output stream of the MAC accumulator.
// master = producer/consumer side (tap sequencer + activation path),
// slave  = the accumulator itself.
interface mac_accumulator_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_accumulator_round_shift_sat.sv
// round_shift_sat: combinational post-processing of a finished window sum.
// Adds bias, rounds half up, arithmetic right shift, saturates to OUT_W.
// Optional macro MAC_ACCUMULATOR_RELU_EN clamps negative results to zero.
module round_shift_sat #(
  parameter int ACC_W  = 24,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic        [3:0]        shift,
  output logic signed [OUT_W-1:0]  res,
  output logic                     ovf
);
  localparam int W = ACC_W + 1;
  localparam logic signed [W-1:0] MAX_V = W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] MIN_V = W'(-(2 ** (OUT_W - 1)));

  function automatic logic signed [W-1:0] round_shift(
    input logic signed [W-1:0] s,
    input logic        [3:0]   sh
  );
    logic signed [W-1:0] rnd;
    rnd = '0;
    if (sh != 4'd0) rnd = W'(1) <<< (sh - 4'd1);
    return (s + rnd) >>> sh;
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic signed [W-1:0] r);
    if (r > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (r < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic signed [W-1:0] sum;
  logic signed [W-1:0] shifted;
  logic        [OUT_W:0] sat;

  // Bias add, round, shift, saturate; optional ReLU after saturation.
  always_comb begin
    sum     = W'(acc) + W'(bias);
    shifted = round_shift(sum, shift);
    sat     = saturate(shifted);
    ovf     = sat[OUT_W];
`ifdef MAC_ACCUMULATOR_RELU_EN
    res     = sat[OUT_W-1] ? '0 : sat[OUT_W-1:0];
`else
    res     = sat[OUT_W-1:0];
`endif
  end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums cfg_taps signed products per window, then applies
// bias/round/shift/saturate and presents one result per window with
// valid/ready handshaking. Optional macro: MAC_ACCUMULATOR_RELU_EN.
module mac_accumulator
  import cnn_pkg::*;
#(
  parameter int IN_W   = DEFAULT_IN_W,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int BIAS_W = DEFAULT_BIAS_W,
  parameter int OUT_W  = DEFAULT_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic        [CNT_W-1:0]  cfg_taps,
  input  logic signed [BIAS_W-1:0] cfg_bias,
  input  logic        [3:0]        cfg_shift,
  mac_accumulator_if.slave         bus,
  output logic                     busy
);
  acc_state_t               state_q, state_d;
  logic        [CNT_W-1:0]  count_q, count_d;
  logic        [CNT_W-1:0]  taps_q, taps_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_final_q, acc_final_d;
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic        [3:0]        shift_q, shift_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;

  logic signed [ACC_W-1:0]  sum;
  logic        [CNT_W-1:0]  taps_eff;
  logic signed [OUT_W-1:0]  post_res;
  logic                     post_ovf;

  round_shift_sat #(
    .ACC_W (ACC_W),
    .BIAS_W(BIAS_W),
    .OUT_W (OUT_W)
  ) u_post (
    .acc  (acc_final_q),
    .bias (bias_q),
    .shift(shift_q),
    .res  (post_res),
    .ovf  (post_ovf)
  );

  // Next-state: tap accumulation in S_ACC, result hand-off in S_POST.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    taps_d      = taps_q;
    acc_d       = acc_q;
    acc_final_d = acc_final_q;
    bias_d      = bias_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    bus.in_ready = (state_q == S_ACC);

    // First tap starts a fresh sum and takes the window length from cfg.
    sum      = (count_q == '0) ? ACC_W'(bus.in_data) : acc_q + ACC_W'(bus.in_data);
    taps_eff = (count_q == '0) ? ((cfg_taps == '0) ? CNT_W'(1) : cfg_taps) : taps_q;

    if (bus.out_valid && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_ACC: begin
        if (bus.in_valid) begin
          acc_d   = sum;
          taps_d  = taps_eff;
          count_d = count_q + CNT_W'(1);
          if (count_q == taps_eff - CNT_W'(1)) begin
            acc_final_d = sum;
            bias_d      = cfg_bias;
            shift_d     = cfg_shift;
            count_d     = '0;
            state_d     = S_POST;
          end
        end
      end
      S_POST: begin
        // A new result overrides the clear from a same-cycle consume.
        if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = post_res;
          out_ovf_d   = post_ovf;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // State and datapath registers; reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      count_q     <= '0;
      taps_q      <= '0;
      acc_q       <= '0;
      acc_final_q <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      taps_q      <= taps_d;
      acc_q       <= acc_d;
      acc_final_q <= acc_final_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Output drive and activity flag.
  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_ovf   = out_ovf_q;
    busy = (count_q != '0) || (state_q == S_POST) || (out_valid_q && !bus.out_ready);
  end
endmodule
